// File: rtl/cim_mem_arbiter_pkg.sv
// Shared CiM memory-access types: source enumeration, address/word types and
// read latency used by the SRAM arbiter and its requesters.
package cim_mem_arbiter_pkg;

    localparam int MEM_ACCESS_SRC_NUM = 7;
    localparam int RD_LAT             = 1;
    localparam int ADDR_W             = 10;
    localparam int WORD_W             = 16;
    localparam int PTR_W              = 3;

    typedef enum logic [PTR_W-1:0] {
        BUS_FSM       = 3'd0,
        LOGIC_FSM     = 3'd1,
        DATA_FILL_FSM = 3'd2,
        WEIGHT_FSM    = 3'd3,
        MAC           = 3'd4,
        LAYERNORM     = 3'd5,
        SOFTMAX       = 3'd6
    } MEM_ACCESS_SRC_T;

    typedef logic [ADDR_W-1:0] TEMP_RES_ADDR_T;
    typedef logic [WORD_W-1:0] STORAGE_WORD_T;

    // Next source index after idx, wrapping from n-1 back to 0.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/cim_mem_arbiter_if.sv
// Bundle of per-source memory access requests driven by the CiM engines.
interface MemAccessSignals
    import cim_mem_arbiter_pkg::*;
#(
    parameter int N_SRC = MEM_ACCESS_SRC_NUM
);

    logic           [N_SRC-1:0] read_req_src;
    logic           [N_SRC-1:0] write_req_src;
    TEMP_RES_ADDR_T [N_SRC-1:0] addr_table;
    STORAGE_WORD_T  [N_SRC-1:0] write_data;

    modport arb (
        input read_req_src,
        input write_req_src,
        input addr_table,
        input write_data
    );

endinterface

// File: rtl/cim_mem_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wrap,
// plus the pointer value to load once the grant is taken.
module rr_arbiter
    import cim_mem_arbiter_pkg::*;
#(
    parameter int N_SRC = MEM_ACCESS_SRC_NUM
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_SRC-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic [PTR_W-1:0] ptr_nxt,
    output logic             any_gnt
);

    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N_SRC)) begin
                sum = sum - (PTR_W+1)'(N_SRC);
            end
            idx = sum[PTR_W-1:0];
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any_gnt  = 1'b1;
            end
        end
    end

    assign ptr_nxt = wrap_inc(gnt_idx, N_SRC);

endmodule

// File: rtl/cim_mem_arbiter.sv
// Single-port SRAM arbiter for the CiM engines: zero-latency round-robin grant
// and a tagged read-return pipeline that routes read data back to its source.
module cim_mem_arbiter
    import cim_mem_arbiter_pkg::*;
#(
    parameter int N_SRC  = MEM_ACCESS_SRC_NUM,
    parameter int RD_LAT = cim_mem_arbiter_pkg::RD_LAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic           [N_SRC-1:0] read_req_src,
    input  logic           [N_SRC-1:0] write_req_src,
    input  TEMP_RES_ADDR_T [N_SRC-1:0] addr_table,
    input  STORAGE_WORD_T  [N_SRC-1:0] write_data,
    output logic           [N_SRC-1:0] gnt,
    output STORAGE_WORD_T              rd_data,
    output logic           [N_SRC-1:0] rd_valid,
    output logic                       mem_en,
    output logic                       mem_wen,
    output TEMP_RES_ADDR_T             mem_addr,
    output STORAGE_WORD_T              mem_wdata,
    input  STORAGE_WORD_T              mem_rdata,
    output logic                       err_multi_op
);

    localparam int LAST = RD_LAT - 1;

    MemAccessSignals #(.N_SRC(N_SRC)) cim_if ();

    assign cim_if.read_req_src  = read_req_src;
    assign cim_if.write_req_src = write_req_src;
    assign cim_if.addr_table    = addr_table;
    assign cim_if.write_data    = write_data;

    logic [N_SRC-1:0] req;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] gnt_idx;
    logic             any_gnt;
    logic             rd_issue;

    logic [RD_LAT-1:0] pipe_vld;
    logic [PTR_W-1:0]  pipe_tag [RD_LAT];
    logic [N_SRC-1:0]  ret_onehot;

    // Holding reset also masks requests so nothing reaches the SRAM.
    assign req = rst_n ? (cim_if.read_req_src | cim_if.write_req_src) : '0;

    rr_arbiter #(
        .N_SRC(N_SRC)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .ptr_nxt (ptr_nxt),
        .any_gnt (any_gnt)
    );

    // A write wins over a read raised by the same source.
    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                mem_wen   = cim_if.write_req_src[i];
                mem_addr  = cim_if.addr_table[i];
                mem_wdata = cim_if.write_data[i];
            end
        end
    end

    assign mem_en   = any_gnt;
    assign rd_issue = any_gnt & ~mem_wen;

    // NOTE: clocked state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (any_gnt) begin
            ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_multi_op <= 1'b0;
        end else if (|(cim_if.read_req_src & cim_if.write_req_src)) begin
            err_multi_op <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // NOTE: tag stages carry no reset; the reset valid bits alone decide whether a tag is used.
    always_ff @(posedge clk) begin
        pipe_tag[0] <= gnt_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    always_comb begin
        ret_onehot                 = '0;
        ret_onehot[pipe_tag[LAST]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pipe_vld[LAST] ? ret_onehot : '0;
            if (pipe_vld[LAST]) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Directed bench for cim_mem_arbiter with a write-first, 1-cycle-latency SRAM model.
module tb_cim_mem_arbiter;
    import cim_mem_arbiter_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic           [6:0]   read_req_src;
    logic           [6:0]   write_req_src;
    TEMP_RES_ADDR_T [6:0]   addr_table;
    STORAGE_WORD_T  [6:0]   write_data;
    logic           [6:0]   gnt;
    STORAGE_WORD_T          rd_data;
    logic           [6:0]   rd_valid;
    logic                   mem_en;
    logic                   mem_wen;
    TEMP_RES_ADDR_T         mem_addr;
    STORAGE_WORD_T          mem_wdata;
    STORAGE_WORD_T          mem_rdata;
    logic                   err_multi_op;

    int n_cmp = 0;
    int n_bad = 0;

    cim_mem_arbiter #(.N_SRC(7), .RD_LAT(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_req_src  (read_req_src),
        .write_req_src (write_req_src),
        .addr_table    (addr_table),
        .write_data    (write_data),
        .gnt           (gnt),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .mem_en        (mem_en),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .err_multi_op  (err_multi_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write-first, read data available one cycle after the access.
    STORAGE_WORD_T tb_mem [int];

    function automatic STORAGE_WORD_T init_word(input TEMP_RES_ADDR_T a);
        return (a == 10'h010) ? 16'h1234 : (16'hA000 | {6'h00, a});
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) begin
                tb_mem[int'(mem_addr)] = mem_wdata;
                mem_rdata <= mem_wdata;
            end else begin
                mem_rdata <= tb_mem.exists(int'(mem_addr)) ? tb_mem[int'(mem_addr)] : init_word(mem_addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_inputs();
        read_req_src  = '0;
        write_req_src = '0;
        addr_table    = '0;
        write_data    = '0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n        = 1'b0;
        read_req_src = 7'b1111111;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (gnt !== 7'b0000000) begin n_bad++; $display("FAIL reset_gnt: got %b want %b", gnt, 7'b0000000); end
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_cmp++; if (rd_valid !== 7'b0000000) begin n_bad++; $display("FAIL reset_rd_valid: got %b want %b", rd_valid, 7'b0000000); end
        n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rd_data: got %h want %h", rd_data, 16'h0000); end
        n_cmp++; if (err_multi_op !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_multi_op); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // Pointer at 0: with every source requesting, BUS_FSM wins.
        n_cmp++; if (gnt !== 7'b0000001) begin n_bad++; $display("FAIL reset_ptr_zero: got %b want %b", gnt, 7'b0000001); end
        clear_inputs();
        idle(1);
    endtask

    task automatic test_single_read();
        @(negedge clk);
        read_req_src[LOGIC_FSM] = 1'b1;
        addr_table[LOGIC_FSM]   = 10'h010;
        #1;
        n_cmp++; if (gnt !== 7'b0000010) begin n_bad++; $display("FAIL single_gnt: got %b want %b", gnt, 7'b0000010); end
        n_cmp++; if (mem_en !== 1'b1 || mem_wen !== 1'b0) begin n_bad++; $display("FAIL single_en_wen: got %b%b want 10", mem_en, mem_wen); end
        n_cmp++; if (mem_addr !== 10'h010) begin n_bad++; $display("FAIL single_addr: got %h want %h", mem_addr, 10'h010); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (rd_valid !== 7'b0000000) begin n_bad++; $display("FAIL single_early: got %b want %b", rd_valid, 7'b0000000); end
        @(negedge clk);
        #1;
        n_cmp++; if (rd_valid !== 7'b0000010) begin n_bad++; $display("FAIL single_rd_valid: got %b want %b", rd_valid, 7'b0000010); end
        n_cmp++; if (rd_data !== 16'h1234) begin n_bad++; $display("FAIL single_rd_data: got %h want %h", rd_data, 16'h1234); end
        @(negedge clk);
        #1;
        n_cmp++; if (rd_valid !== 7'b0000000) begin n_bad++; $display("FAIL single_valid_drop: got %b want %b", rd_valid, 7'b0000000); end
        n_cmp++; if (rd_data !== 16'h1234) begin n_bad++; $display("FAIL single_data_hold: got %h want %h", rd_data, 16'h1234); end
        idle(1);
    endtask

    task automatic test_contention();
        logic [6:0]    exp_gnt [5];
        logic [6:0]    exp_rv  [5];
        STORAGE_WORD_T exp_d   [5];
        logic [6:0]    seen;
        exp_gnt = '{7'b0010000, 7'b0100000, 7'b1000000, 7'b0000000, 7'b0000000};
        exp_rv  = '{7'b0000000, 7'b0000000, 7'b0010000, 7'b0100000, 7'b1000000};
        exp_d   = '{16'h0000, 16'h0000, 16'hA104, 16'hA105, 16'hA106};
        seen    = '0;
        do_reset();
        read_req_src[MAC]       = 1'b1;
        read_req_src[LAYERNORM] = 1'b1;
        read_req_src[SOFTMAX]   = 1'b1;
        addr_table[MAC]         = 10'h104;
        addr_table[LAYERNORM]   = 10'h105;
        addr_table[SOFTMAX]     = 10'h106;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk);
                read_req_src = read_req_src & ~seen;
            end
            #1;
            seen = gnt;
            n_cmp++; if (gnt !== exp_gnt[c]) begin n_bad++; $display("FAIL contention_gnt[%0d]: got %b want %b", c, gnt, exp_gnt[c]); end
            n_cmp++; if (rd_valid !== exp_rv[c]) begin n_bad++; $display("FAIL contention_rd_valid[%0d]: got %b want %b", c, rd_valid, exp_rv[c]); end
            n_cmp++; if (rd_data !== exp_d[c]) begin n_bad++; $display("FAIL contention_rd_data[%0d]: got %h want %h", c, rd_data, exp_d[c]); end
        end
        idle(1);
    endtask

    task automatic test_wrap();
        logic [6:0] seen;
        @(negedge clk);
        #1;
        // Idle cycles must leave the pointer on BUS_FSM after the SOFTMAX grant.
        n_cmp++; if (gnt !== 7'b0000000 || mem_en !== 1'b0) begin n_bad++; $display("FAIL idle_no_gnt: got %b/%b want 0000000/0", gnt, mem_en); end
        @(negedge clk);
        read_req_src[SOFTMAX] = 1'b1;
        read_req_src[BUS_FSM] = 1'b1;
        #1;
        seen = gnt;
        n_cmp++; if (gnt !== 7'b0000001) begin n_bad++; $display("FAIL wrap_first: got %b want %b", gnt, 7'b0000001); end
        @(negedge clk);
        read_req_src = read_req_src & ~seen;
        #1;
        n_cmp++; if (gnt !== 7'b1000000) begin n_bad++; $display("FAIL wrap_second: got %b want %b", gnt, 7'b1000000); end
        idle(4);
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        write_req_src[DATA_FILL_FSM] = 1'b1;
        addr_table[DATA_FILL_FSM]    = 10'h3FF;
        write_data[DATA_FILL_FSM]    = 16'hBEEF;
        #1;
        n_cmp++; if (gnt !== 7'b0000100 || mem_wen !== 1'b1) begin n_bad++; $display("FAIL wr_gnt: got %b/%b want 0000100/1", gnt, mem_wen); end
        n_cmp++; if (mem_addr !== 10'h3FF || mem_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL wr_bus: got %h/%h want 3ff/beef", mem_addr, mem_wdata); end
        @(negedge clk);
        clear_inputs();
        read_req_src[MAC] = 1'b1;
        addr_table[MAC]   = 10'h3FF;
        #1;
        n_cmp++; if (gnt !== 7'b0010000 || mem_wen !== 1'b0) begin n_bad++; $display("FAIL rd_after_wr_gnt: got %b/%b want 0010000/0", gnt, mem_wen); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (rd_valid !== 7'b0000000) begin n_bad++; $display("FAIL write_no_valid: got %b want %b", rd_valid, 7'b0000000); end
        @(negedge clk);
        #1;
        n_cmp++; if (rd_valid !== 7'b0010000) begin n_bad++; $display("FAIL rd_after_wr_valid: got %b want %b", rd_valid, 7'b0010000); end
        n_cmp++; if (rd_data !== 16'hBEEF) begin n_bad++; $display("FAIL rd_after_wr_data: got %h want %h", rd_data, 16'hBEEF); end
        idle(1);
    endtask

    task automatic test_dual_op();
        @(negedge clk);
        #1;
        n_cmp++; if (err_multi_op !== 1'b0) begin n_bad++; $display("FAIL dual_err_before: got %b want 0", err_multi_op); end
        read_req_src[MAC]  = 1'b1;
        write_req_src[MAC] = 1'b1;
        addr_table[MAC]    = 10'h005;
        write_data[MAC]    = 16'h0007;
        #1;
        n_cmp++; if (gnt !== 7'b0010000 || mem_wen !== 1'b1) begin n_bad++; $display("FAIL dual_wen: got %b/%b want 0010000/1", gnt, mem_wen); end
        n_cmp++; if (mem_addr !== 10'h005 || mem_wdata !== 16'h0007) begin n_bad++; $display("FAIL dual_bus: got %h/%h want 005/0007", mem_addr, mem_wdata); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++; if (err_multi_op !== 1'b1) begin n_bad++; $display("FAIL dual_err_set: got %b want 1", err_multi_op); end
        n_cmp++; if (rd_valid !== 7'b0000000) begin n_bad++; $display("FAIL dual_valid_1: got %b want %b", rd_valid, 7'b0000000); end
        @(negedge clk);
        #1;
        n_cmp++; if (rd_valid !== 7'b0000000) begin n_bad++; $display("FAIL dual_valid_2: got %b want %b", rd_valid, 7'b0000000); end
        @(negedge clk);
        #1;
        n_cmp++; if (err_multi_op !== 1'b1) begin n_bad++; $display("FAIL dual_err_sticky: got %b want 1", err_multi_op); end
        idle(1);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        read_req_src[LOGIC_FSM] = 1'b1;
        addr_table[LOGIC_FSM]   = 10'h010;
        #1;
        n_cmp++; if (gnt !== 7'b0000010) begin n_bad++; $display("FAIL midrst_gnt: got %b want %b", gnt, 7'b0000010); end
        @(negedge clk);
        clear_inputs();
        read_req_src = 7'b1111111;
        rst_n        = 1'b0;
        #1;
        n_cmp++; if (gnt !== 7'b0000000 || mem_en !== 1'b0) begin n_bad++; $display("FAIL midrst_masked: got %b/%b want 0000000/0", gnt, mem_en); end
        n_cmp++; if (err_multi_op !== 1'b0) begin n_bad++; $display("FAIL midrst_err_clear: got %b want 0", err_multi_op); end
        @(negedge clk);
        #1;
        n_cmp++; if (rd_valid !== 7'b0000000) begin n_bad++; $display("FAIL midrst_valid_in_reset: got %b want %b", rd_valid, 7'b0000000); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (gnt !== 7'b0000001) begin n_bad++; $display("FAIL midrst_ptr_zero: got %b want %b", gnt, 7'b0000001); end
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (rd_valid !== 7'b0000000) begin n_bad++; $display("FAIL midrst_no_return[%0d]: got %b want %b", c, rd_valid, 7'b0000000); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_wrap();
        test_write_then_read();
        test_dual_op();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cim_mem_arbiter.md
CIM_MEM_ARBITER -- requirements
Module: cim_mem_arbiter

Interface
REQ-001 The block SHALL have the parameter N_SRC, default 7 (MEM_ACCESS_SRC_NUM), meaning the number of memory access sources.
REQ-002 The block SHALL have the parameter RD_LAT, default 1, meaning the SRAM read latency in cycles.
REQ-003 The block SHALL have the port clk, input, 1 bit: single clock, rising edge; all logic runs in this one clock domain.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have the port read_req_src, input, N_SRC bits: per-source read request, indexed by MEM_ACCESS_SRC_T.
REQ-006 The block SHALL have the port write_req_src, input, N_SRC bits: per-source write request, indexed by MEM_ACCESS_SRC_T.
REQ-007 The block SHALL have the port addr_table, input, N_SRC x TEMP_RES_ADDR_T: per-source address.
REQ-008 The block SHALL have the port write_data, input, N_SRC x STORAGE_WORD_T: per-source write word.
REQ-009 The block SHALL have the port gnt, output, N_SRC bits: one-hot grant; the access is issued this cycle.
REQ-010 The block SHALL have the port rd_data, output, STORAGE_WORD_T: read word returned.
REQ-011 The block SHALL have the port rd_valid, output, N_SRC bits: one-hot; rd_data belongs to this source.
REQ-012 The block SHALL have the port mem_en, output, 1 bit: SRAM access enable.
REQ-013 The block SHALL have the port mem_wen, output, 1 bit: SRAM write enable (1 = write, 0 = read).
REQ-014 The block SHALL have the port mem_addr, output, TEMP_RES_ADDR_T: SRAM address.
REQ-015 The block SHALL have the port mem_wdata, output, STORAGE_WORD_T: SRAM write word.
REQ-016 The block SHALL have the port mem_rdata, input, STORAGE_WORD_T: SRAM read word, valid RD_LAT cycles after a read.
REQ-017 The block SHALL have the port err_multi_op, output, 1 bit: sticky; a source raised read and write in the same cycle.

Function
REQ-018 The block SHALL issue at most one SRAM access per cycle (single-port SRAM).
REQ-019 Arbitration SHALL be round-robin over the sources whose read_req_src or write_req_src bit is high, starting from the source after the last granted one.
REQ-020 The round-robin pointer SHALL be 3 bits, reset to 0 (BUS_FSM), and SHALL advance only on a grant.
REQ-021 gnt, mem_en, mem_wen, mem_addr and mem_wdata SHALL be combinational from the requests and the pointer, giving zero-cycle grant latency.
REQ-022 A requester SHALL hold its request, address and data stable until it sees gnt; the block SHALL NOT buffer ungranted requests.
REQ-023 When a source raises both read and write in one cycle, the block SHALL perform the write, drop the read, and set err_multi_op until reset.
REQ-024 A read granted in cycle N SHALL produce rd_valid[src] = 1 and rd_data = mem_rdata, both registered, in cycle N+RD_LAT+1; this is 2 cycles at the default RD_LAT.
REQ-025 The read-return pipeline SHALL hold a source tag and a valid bit per stage and SHALL accept a new read every cycle.
REQ-026 Writes SHALL produce no rd_valid.
REQ-027 A read to the address written in the preceding cycle SHALL return the new data; the SRAM is write-first and the block adds no forwarding.
REQ-028 With no requests, mem_en = 0, gnt = 0 and the pointer SHALL hold.
REQ-029 Pointer wrap: after source N_SRC-1 the search SHALL continue at source 0.
REQ-030 rd_data SHALL hold its last value when rd_valid = 0.

Reset
REQ-031 On rst_n low, asynchronously: pointer = 0, all pipeline valid bits = 0, rd_valid = 0, rd_data = 0, err_multi_op = 0.
REQ-032 Reads in flight at reset SHALL be discarded and never return after reset.
REQ-033 While rst_n is low, mem_en and gnt SHALL be 0.

Structure
REQ-034 MEM_ACCESS_SRC_T, MEM_ACCESS_SRC_NUM, TEMP_RES_ADDR_T, STORAGE_WORD_T and RD_LAT SHALL reside in the shared types/cim package.
REQ-035 The block SHALL instantiate exactly one sub-module, rr_arbiter, parameterised by N_SRC, taking a request vector and producing a one-hot grant plus pointer update.
REQ-036 The block SHALL connect to the CiM through the MemAccessSignals interface (read_req_src, write_req_src, addr_table, write_data).

Verification
REQ-037 Single read: LOGIC_FSM reads addr 0x010 holding 0x1234 -> gnt[1] in the same cycle, then rd_valid = 0b0000010 with rd_data = 0x1234 two cycles later.
REQ-038 Contention: MAC, LAYERNORM and SOFTMAX request reads together from reset -> grants in order 4, 5, 6 on 3 consecutive cycles, each rd_valid tagged correctly.
REQ-039 Wrap: SOFTMAX granted last, then SOFTMAX and BUS_FSM both request -> BUS_FSM granted first.
REQ-040 Write then read: DATA_FILL_FSM writes 0xBEEF to 0x3FF, then MAC reads 0x3FF in the next cycle -> rd_data = 0xBEEF.
REQ-041 Dual op: MAC sets read and write to addr 5 with data 0x0007 -> mem_wen = 1, no rd_valid, err_multi_op = 1 and stays 1.
REQ-042 Reset mid-read: assert rst_n low one cycle after a read grant -> no rd_valid is ever produced and the pointer = 0.
